// File: rtl/blink_measure.sv
// Receive-side pulse-train meter: measures period and high time of a looped-back
// blink line in CLK cycles and flags a line that has stopped toggling.
module blink_measure #(
    parameter int             W       = 23,
    parameter logic [W-1:0]   TIMEOUT = 23'd7_500_000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         sig_in,
    output logic [W-1:0] period_out,
    output logic [W-1:0] high_out,
    output logic         valid,
    output logic         timeout,
    output logic         level_out,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic         s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] high_hold_q, high_hold_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] high_q, high_d;
    logic         valid_q, valid_d;
    logic         timeout_q, timeout_d;
    logic         level_q, level_d;
    logic         busy_q, busy_d;
    logic         rise, fall;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    always_comb begin
        s1_d        = sig_in;
        s2_d        = s1_q;
        s3_d        = s2_q;
        level_d     = s2_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_hold_d = high_hold_q;
        period_d    = period_q;
        high_d      = high_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            HIGH: begin
                cnt_d = cnt_q + CNT_ONE;
                if (fall) begin
                    state_d     = LOW;
                    high_hold_d = cnt_q;
                end else if (cnt_q == TIMEOUT) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            LOW: begin
                cnt_d = cnt_q + CNT_ONE;
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = CNT_ONE;
                    // A period of exactly TIMEOUT is rejected, but its rise still arms the next one.
                    if (cnt_q == TIMEOUT) begin
                        timeout_d = 1'b1;
                    end else begin
                        period_d  = cnt_q;
                        high_d    = high_hold_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                    end
                end else if (cnt_q == TIMEOUT) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            high_hold_q <= '0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            level_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_hold_q <= high_hold_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            level_q     <= level_d;
            busy_q      <= busy_d;
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;
    assign level_out  = level_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_blink_measure.sv
// Directed bench for blink_measure with TIMEOUT shortened to 100 cycles.
module tb_blink_measure;

    localparam int W = 23;

    logic         clk = 1'b0;
    logic         rst;
    logic         sig_in;
    logic [W-1:0] period_out;
    logic [W-1:0] high_out;
    logic         valid;
    logic         timeout;
    logic         level_out;
    logic         busy;

    always #5 clk = ~clk;

    blink_measure #(
        .W       (W),
        .TIMEOUT (23'd100)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .sig_in     (sig_in),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .timeout    (timeout),
        .level_out  (level_out),
        .busy       (busy)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   vcnt  = 0;
    int   vbad  = 0;
    int   vgap  = 0;
    int   base  = 0;
    int   exp_p = 0;
    int   exp_h = 0;
    logic mon_en     = 1'b1;
    logic valid_prev = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            sig_in = v;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Every valid strobe is checked against the current expected measurement.
    always @(negedge clk) begin
        if (valid) begin
            vcnt++;
            if (mon_en && (int'(period_out) != exp_p || int'(high_out) != exp_h || timeout || !busy)) begin
                vbad++;
                $display("FAIL valid_fields: period %0d high %0d timeout %0b busy %0b, expected period %0d high %0d timeout 0 busy 1",
                         period_out, high_out, timeout, busy, exp_p, exp_h);
            end
            if (valid_prev) begin
                vgap++;
                $display("FAIL valid_back_to_back at time %0t", $time);
            end
        end
        valid_prev = valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period", int'(period_out), 0);
        chk("rst_high", int'(high_out), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_level", int'(level_out), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // Period 40 / high 10, three periods
        exp_p = 40; exp_h = 10; base = vcnt;
        repeat (3) pulse(10, 30);
        chk("t1_count", vcnt - base, 2);
        chk("t1_period", int'(period_out), 40);
        chk("t1_high", int'(high_out), 10);
        chk("t1_timeout", int'(timeout), 0);
        chk("t1_busy", int'(busy), 1);

        // Stuck high: rise completes a 40-cycle period, then times out 100 cycles later
        @(negedge clk);
        sig_in = 1'b1;
        repeat (102) @(negedge clk);
        chk("t3_pre_timeout", int'(timeout), 0);
        chk("t3_pre_busy", int'(busy), 1);
        @(negedge clk);
        chk("t3_timeout", int'(timeout), 1);
        chk("t3_busy", int'(busy), 0);
        chk("t3_level", int'(level_out), 1);
        chk("t3_period_held", int'(period_out), 40);
        hold(1'b0, 25);
        exp_p = 30; exp_h = 5; base = vcnt;
        pulse(5, 25);
        chk("t3_rearm_count", vcnt - base, 0);
        chk("t3_rearm_timeout", int'(timeout), 1);
        chk("t3_rearm_busy", int'(busy), 1);
        repeat (2) pulse(5, 25);
        chk("t3_count", vcnt - base, 2);
        chk("t3_period", int'(period_out), 30);
        chk("t3_high", int'(high_out), 5);
        chk("t3_timeout_clr", int'(timeout), 0);

        // Toggle every cycle: period 2, high 1
        do_reset();
        exp_p = 2; exp_h = 1; base = vcnt;
        repeat (10) pulse(1, 1);
        hold(1'b0, 5);
        chk("t2_count", vcnt - base, 9);
        chk("t2_period", int'(period_out), 2);
        chk("t2_high", int'(high_out), 1);
        chk("t2_gap", vgap, 0);

        // Stuck low after a fall
        do_reset();
        base = vcnt;
        pulse(10, 0);
        hold(1'b0, 110);
        chk("t4_low_timeout", int'(timeout), 1);
        chk("t4_low_level", int'(level_out), 0);
        chk("t4_low_busy", int'(busy), 0);
        chk("t4_low_count", vcnt - base, 0);

        // Period exactly TIMEOUT is never reported
        do_reset();
        base = vcnt;
        repeat (3) pulse(10, 90);
        chk("t4_p100_count", vcnt - base, 0);
        chk("t4_p100_timeout", int'(timeout), 1);
        chk("t4_p100_period", int'(period_out), 0);

        // Period TIMEOUT-1 is reported
        do_reset();
        exp_p = 99; exp_h = 10; base = vcnt;
        repeat (3) pulse(10, 89);
        chk("t4_p99_count", vcnt - base, 2);
        chk("t4_p99_period", int'(period_out), 99);
        chk("t4_p99_timeout", int'(timeout), 0);

        // Reset in the middle of a high phase
        do_reset();
        exp_p = 40; exp_h = 10; base = vcnt;
        repeat (2) pulse(10, 30);
        chk("t5_pre_period", int'(period_out), 40);
        hold(1'b1, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_period", int'(period_out), 0);
        chk("t5_rst_high", int'(high_out), 0);
        chk("t5_rst_valid", int'(valid), 0);
        chk("t5_rst_timeout", int'(timeout), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_level", int'(level_out), 0);
        mon_en = 1'b0;
        base = vcnt;
        hold(1'b1, 3);
        hold(1'b0, 30);
        chk("t5_arm_count", vcnt - base, 0);
        repeat (2) pulse(10, 30);
        chk("t5_count", vcnt - base, 2);
        chk("t5_period", int'(period_out), 40);
        chk("t5_high", int'(high_out), 10);
        mon_en = 1'b1;

        // Latency from sig_in rising to valid
        do_reset();
        exp_p = 40; exp_h = 10;
        pulse(10, 30);
        @(negedge clk);
        sig_in = 1'b1;
        @(negedge clk);
        chk("lat_e0", int'(valid), 0);
        @(negedge clk);
        chk("lat_e1", int'(valid), 0);
        @(negedge clk);
        chk("lat_e2", int'(valid), 1);
        chk("lat_period", int'(period_out), 40);
        @(negedge clk);
        chk("lat_e3", int'(valid), 0);
        hold(1'b0, 5);

        chk("valid_fields_total", vbad, 0);
        chk("valid_gap_total", vgap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
